fire6_ofm_writer: RTL and testbench

FIRE6_OFM_WRITER -- requirements
Module: fire6_ofm_writer

---
 rtl/fire_pkg.sv | 32 +++
 rtl/fire6_ofm_writer.sv | 130 +++++++++++++
 tb/tb_fire6_ofm_writer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fire_pkg.sv
// Shared constants and state encoding for the fire6 output feature-map writer.
// Helper functions let the writer re-derive its sizes from its own parameters.
package fire_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DSP_NO = 256;
  localparam int DEF_LANES  = 8;
  localparam int DEF_WOUT   = 16;

  function automatic int beats_of(input int dsp_no, input int lanes);
    return dsp_no / lanes;
  endfunction

  function automatic int pixels_of(input int wout);
    return wout * wout;
  endfunction

  function automatic int addr_w_of(input int wout, input int dsp_no, input int lanes);
    return $clog2(pixels_of(wout) * beats_of(dsp_no, lanes));
  endfunction

  localparam int BEATS  = beats_of(DEF_DSP_NO, DEF_LANES);
  localparam int PIXELS = pixels_of(DEF_WOUT);
  localparam int ADDR_W = addr_w_of(DEF_WOUT, DEF_DSP_NO, DEF_LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fire6_ofm_writer.sv
// Drains one captured DSP_NO-channel vector per sample into RAM, LANES words per beat.
// A sample arriving on the visible last beat chains straight into the next vector.
module fire6_ofm_writer
  import fire_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DSP_NO = DEF_DSP_NO,
  parameter int LANES  = DEF_LANES,
  parameter int WOUT   = DEF_WOUT,
  localparam int NBEAT = beats_of(DSP_NO, LANES),
  localparam int NPIX  = pixels_of(WOUT),
  localparam int AW    = addr_w_of(WOUT, DSP_NO, LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   sample_i,
  input  logic [WIDTH-1:0]       ofm_i [DSP_NO],
  output logic                   wr_en_o,
  output logic [AW-1:0]          wr_addr_o,
  output logic [WIDTH*LANES-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o
);

  localparam int BW = $clog2(NBEAT);
  localparam int PW = $clog2(NPIX);
  localparam int CW = BW + 1;

  state_t                        state, state_nx;
  // cnt = next beat to issue; cnt == NBEAT means beat NBEAT-1 is on the bus now
  logic [CW-1:0]                 cnt, cnt_nx;
  logic [PW-1:0]                 pix, pix_nx;
  logic [DSP_NO-1:0][WIDTH-1:0]  shadow, ofm_pk;
  logic [BW-1:0]                 beat_sel;
  logic                          capture, issue, from_ofm, ovr_set, wr_en_nx, done_nx, last_pix;
  logic [AW-1:0]                 addr_nx;
  logic [WIDTH*LANES-1:0]        data_nx;

  always_comb
    for (int c = 0; c < DSP_NO; c++) ofm_pk[c] = ofm_i[c];

  assign last_pix = (pix == PW'(NPIX - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pix_nx   = pix;
    capture  = 1'b0;
    issue    = 1'b0;
    from_ofm = 1'b0;
    ovr_set  = 1'b0;
    wr_en_nx = 1'b0;
    beat_sel = cnt[BW-1:0];
    if (!en_i) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      pix_nx   = '0;
    end else begin
      unique case (state)
        IDLE: if (sample_i) begin
          capture  = 1'b1;
          state_nx = WRITE;
          cnt_nx   = '0;
        end
        WRITE: if (cnt != CW'(NBEAT)) begin
          issue    = 1'b1;
          wr_en_nx = 1'b1;
          cnt_nx   = cnt + CW'(1);
          ovr_set  = sample_i;
        end else if (sample_i && !last_pix) begin
          // chained vector: beat 0 bypasses the shadow bank, which loads this edge
          capture  = 1'b1;
          issue    = 1'b1;
          from_ofm = 1'b1;
          wr_en_nx = 1'b1;
          pix_nx   = pix + PW'(1);
          cnt_nx   = CW'(1);
          beat_sel = '0;
        end else begin
          ovr_set = sample_i;
          cnt_nx  = '0;
          if (last_pix) state_nx = DONE;
          else begin
            state_nx = IDLE;
            pix_nx   = pix + PW'(1);
          end
        end
        DONE:    ovr_set  = sample_i;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign addr_nx = AW'(pix_nx) * AW'(NBEAT) + AW'(beat_sel);
  assign data_nx = from_ofm ? ofm_pk[0 +: LANES]
                            : shadow[int'(beat_sel) * LANES +: LANES];
  assign done_nx = en_i && (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pix       <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pix     <= pix_nx;
      wr_en_o <= wr_en_nx;
      done_o  <= done_nx;
      if (issue) begin
        wr_addr_o <= addr_nx;
        wr_data_o <= data_nx;
      end
      if (ovr_set) overrun_o <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (capture) shadow <= ofm_pk;

  assign busy_o = wr_en_o;

endmodule

// File: tb/tb_fire6_ofm_writer.sv
// Directed bench for fire6_ofm_writer: single vector, full layer, chained and
// dropped samples, enable drop and asynchronous reset mid-vector.
module tb_fire6_ofm_writer;

  logic          clk = 1'b0;
  logic          rst, en, sample;
  logic [15:0]   ofm  [256];
  logic [15:0]   refv [256];
  logic          wr_en, busy, done, ovr;
  logic [12:0]   addr;
  logic [127:0]  data;
  int            n_chk = 0;
  int            n_pass = 0;

  fire6_ofm_writer dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .sample_i  (sample),
    .ofm_i     (ofm),
    .wr_en_o   (wr_en),
    .wr_addr_o (addr),
    .wr_data_o (data),
    .busy_o    (busy),
    .done_o    (done),
    .overrun_o (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic set_ofm(input int seed);
    for (int c = 0; c < 256; c++) ofm[c] = 16'(seed * 256 + c);
  endtask

  function automatic logic [127:0] exp_beat(input int b);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[k*16 +: 16] = refv[b*8 + k];
    return r;
  endfunction

  // sample from IDLE; ofm is scrambled right after the capture edge
  task automatic do_sample(input int seed);
    set_ofm(seed);
    refv   = ofm;
    sample = 1'b1;
    tick();
    chk("cap_wr_en", wr_en, 1'b0);
    set_ofm(seed + 55);
  endtask

  // check n visible beats from a0; optionally raise sample while beat samp_at is visible
  task automatic beats(input int a0, input int n, input int samp_at, input bit acc, input int seed);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("wr_en", wr_en, 1'b1);
      chk("busy", busy, 1'b1);
      chk("addr", addr, 128'(a0 + i));
      chk("data", data, exp_beat((a0 + i) % 32));
      if (i == samp_at) begin
        set_ofm(seed);
        sample = 1'b1;
        if (acc) refv = ofm;
      end else set_ofm(seed + 97 + i);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sample = 1'b0;
    set_ofm(0);
    refv = ofm;
    #12;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_addr", addr, 13'd0);
    chk("rst_data", data, 128'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1;
    tick();

    // single vector, ofm[c] = c
    do_sample(0);
    beats(0, 1, -1, 1'b0, 0);
    chk("beat0_const", data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    beats(1, 31, -1, 1'b0, 0);
    tick();
    chk("t1_end_wr_en", wr_en, 1'b0);
    chk("t1_end_busy", busy, 1'b0);
    chk("t1_ovr", ovr, 1'b0);

    // full layer, one sample every 65 cycles
    en = 1'b0; tick(); en = 1'b1;
    for (int p = 0; p < 256; p++) begin
      do_sample(p + 1);
      beats(p * 32, 32, -1, 1'b0, 3);
      tick();
      chk("gap_wr_en", wr_en, 1'b0);
      chk("gap_done", done, 1'b0);
      if (p == 255) begin
        tick();
        chk("full_done", done, 1'b1);
        chk("full_ovr", ovr, 1'b0);
      end else repeat (31) tick();
    end
    repeat (3) tick();
    chk("done_hold", done, 1'b1);

    // chained sample on beat 31 of vector 0
    en = 1'b0; tick();
    chk("en_low_done", done, 1'b0);
    en = 1'b1;
    do_sample(10);
    beats(0, 32, 31, 1'b1, 11);
    beats(32, 32, -1, 1'b0, 12);
    tick();
    chk("chain_end_wr_en", wr_en, 1'b0);
    chk("chain_ovr", ovr, 1'b0);

    // dropped sample on beat 10 of vector 2
    do_sample(12);
    beats(64, 32, 10, 1'b0, 13);
    tick();
    chk("drop_ovr", ovr, 1'b1);
    chk("drop_end_wr_en", wr_en, 1'b0);

    // en dropped at beat 15 of vector 3
    do_sample(14);
    beats(96, 16, -1, 1'b0, 15);
    en = 1'b0;
    tick();
    chk("en_drop_wr_en", wr_en, 1'b0);
    chk("en_drop_busy", busy, 1'b0);
    chk("en_drop_ovr", ovr, 1'b1);
    en = 1'b1;
    do_sample(16);
    beats(0, 8, -1, 1'b0, 17);

    // async reset mid-vector
    rst = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_addr", addr, 13'd0);
    chk("arst_data", data, 128'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_ovr", ovr, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst_wr_en", wr_en, 1'b0);
    tick();
    chk("post_rst_idle", wr_en, 1'b0);

    // back-to-back layer; the sample on the final beat is an overrun
    do_sample(20);
    for (int p = 0; p < 256; p++) begin
      if (p == 255) chk("b2b_ovr_pre", ovr, 1'b0);
      beats(p * 32, 32, 31, (p != 255), 21 + p);
    end
    tick();
    chk("b2b_end_wr_en", wr_en, 1'b0);
    chk("b2b_ovr", ovr, 1'b1);
    chk("b2b_done_early", done, 1'b0);
    tick();
    chk("b2b_done", done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
